// File: rtl/spi_pkg.sv
// Shared definitions for the SPI clock / chip-select sequencer:
// FSM state encoding, default field widths and {CPOL,CPHA} mode codes.
package spi_pkg;

  localparam int unsigned SPI_DIV_W = 8;
  localparam int unsigned SPI_CNT_W = 6;

  typedef enum logic [2:0] {
    SPI_IDLE,
    SPI_SETUP,
    SPI_RUN,
    SPI_HOLD,
    SPI_GAP
  } spi_state_e;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_tick_div.sv
// Half-period divider: counts 0..div while enabled and flags the last
// count of each period, so the consumer acts every div+1 cycles.
// Ports:
//   clk, rst : clock, async active-high reset
//   en       : run enable; counter held at zero while low
//   div      : terminal count (period = div+1 cycles)
//   tick_c   : combinational, high in the last cycle of each period
module spi_tick_div #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div,
  output logic         tick_c
);

  logic [W-1:0] cnt;

  // Combinational so the consumer's registered update lands exactly on
  // the period boundary edge.
  assign tick_c = en && (cnt == div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI master clock and chip-select sequencer with programmable half-period,
// all four CPOL/CPHA modes, framed chip select and per-edge strobes.
// Ports:
//   m_clk, rst              : system clock, async active-high reset
//   cfg_div                 : half-period H = cfg_div+1 cycles
//   cfg_cpol, cfg_cpha      : clock polarity / phase
//   nbits                   : bits per frame, 0 means 2^CNT_W
//   start                   : frame request, honoured only when idle
//   busy, done              : frame in progress / end-of-frame pulse
//   spi_clk, spi_cs_n       : serial clock and active-low chip select
//   lead_edge, trail_edge   : strobes on leading / trailing spi_clk toggles
//   sample_stb, shift_stb   : datapath strobes mapped from edges by CPHA
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = SPI_DIV_W,
  parameter int unsigned CNT_W = SPI_CNT_W
) (
  input  logic             m_clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_cpol,
  input  logic             cfg_cpha,
  input  logic [CNT_W-1:0] nbits,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             spi_clk,
  output logic             spi_cs_n,
  output logic             lead_edge,
  output logic             trail_edge,
  output logic             sample_stb,
  output logic             shift_stb
);

  localparam int unsigned EDGE_W = CNT_W + 1;

  spi_state_e        state;
  logic [DIV_W-1:0]  div_q;
  logic              cpol_q;
  logic              cpha_q;
  logic [CNT_W-1:0]  nbits_q;
  logic [EDGE_W-1:0] edge_cnt;
  logic [EDGE_W-1:0] edge_nxt_c;
  logic [EDGE_W-1:0] edge_last_c;
  logic              is_lead_c;
  logic              div_en_c;
  logic              tick_c;

  assign div_en_c = (state != SPI_IDLE);

  // Edge counter holds the 0-based index of the latest toggle; the last
  // index 2N-1 = {N-1,1} also covers nbits=0 (N=2^CNT_W) without overflow.
  assign edge_nxt_c  = edge_cnt + EDGE_W'(1);
  assign edge_last_c = {nbits_q - CNT_W'(1), 1'b1};

  // Toggle leaving SETUP is index 0 (leading); even indices lead.
  assign is_lead_c = (state == SPI_SETUP) || !edge_nxt_c[0];

  spi_tick_div #(.W(DIV_W)) u_div (
    .clk    (m_clk),
    .rst    (rst),
    .en     (div_en_c),
    .div    (div_q),
    .tick_c (tick_c)
  );

  // Frame sequencer with registered outputs.
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) begin
      state      <= SPI_IDLE;
      div_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      nbits_q    <= '0;
      edge_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      spi_clk    <= 1'b0;
      spi_cs_n   <= 1'b1;
      lead_edge  <= 1'b0;
      trail_edge <= 1'b0;
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
    end else begin
      done       <= 1'b0;
      lead_edge  <= 1'b0;
      trail_edge <= 1'b0;
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;

      case (state)
        SPI_IDLE: begin
          spi_clk <= cfg_cpol;
          if (start) begin
            div_q    <= cfg_div;
            cpol_q   <= cfg_cpol;
            cpha_q   <= cfg_cpha;
            nbits_q  <= nbits;
            edge_cnt <= '0;
            busy     <= 1'b1;
            spi_cs_n <= 1'b0;
            state    <= SPI_SETUP;
          end
        end

        SPI_SETUP, SPI_RUN: begin
          if (tick_c) begin
            spi_clk    <= ~spi_clk;
            lead_edge  <= is_lead_c;
            trail_edge <= !is_lead_c;
            sample_stb <= cpha_q ? !is_lead_c : is_lead_c;
            shift_stb  <= cpha_q ? is_lead_c : !is_lead_c;
            if (state == SPI_SETUP) begin
              edge_cnt <= '0;
              state    <= SPI_RUN;
            end else begin
              edge_cnt <= edge_nxt_c;
              if (edge_nxt_c == edge_last_c) begin
                state <= SPI_HOLD;
              end
            end
          end
        end

        SPI_HOLD: begin
          if (tick_c) begin
            spi_cs_n <= 1'b1;
            done     <= 1'b1;
            state    <= SPI_GAP;
          end
        end

        SPI_GAP: begin
          if (tick_c) begin
            busy     <= 1'b0;
            edge_cnt <= '0;
            state    <= SPI_IDLE;
          end
        end

        default: state <= SPI_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Scoreboard bench for spi_sclk_gen: stimulus pushes the expected output
// events of each frame, a negedge monitor pops and compares them.
module tb_spi_sclk_gen;
  import spi_pkg::*;

  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 6;
  localparam int BIG = 1000000;

  logic             m_clk = 1'b0;
  logic             rst;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_cpol;
  logic             cfg_cpha;
  logic [CNT_W-1:0] nbits;
  logic             start;
  logic             busy, done, spi_clk, spi_cs_n;
  logic             lead_edge, trail_edge, sample_stb, shift_stb;

  spi_sclk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .m_clk      (m_clk),
    .rst        (rst),
    .cfg_div    (cfg_div),
    .cfg_cpol   (cfg_cpol),
    .cfg_cpha   (cfg_cpha),
    .nbits      (nbits),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .spi_clk    (spi_clk),
    .spi_cs_n   (spi_cs_n),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .sample_stb (sample_stb),
    .shift_stb  (shift_stb)
  );

  always #5 m_clk = ~m_clk;

  typedef struct {
    int         t;
    logic [7:0] sig;  // {spi_clk, spi_cs_n, busy, done, lead, trail, sample, shift}
  } ev_t;

  ev_t exp_q[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;

  always @(posedge m_clk) cyc <= cyc + 1;

  // Monitor: any strobe, done, or cs_n/busy change is an event to match.
  logic       prev_cs   = 1'b1;
  logic       prev_busy = 1'b0;
  logic [7:0] mon_s;
  ev_t        mon_e;

  always @(negedge m_clk) begin
    mon_s = {spi_clk, spi_cs_n, busy, done, lead_edge, trail_edge, sample_stb, shift_stb};
    if (!rst && (mon_s[4:0] != 5'b0 || spi_cs_n != prev_cs || busy != prev_busy)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event t=%0d got=%b required=none", cyc, mon_s);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.t != cyc || mon_e.sig != mon_s) begin
          bad++;
          $display("FAIL event t=%0d got=%b required t=%0d sig=%b", cyc, mon_s, mon_e.t, mon_e.sig);
        end
      end
    end
    prev_cs   = spi_cs_n;
    prev_busy = busy;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push_ev(input int t, input logic [7:0] s);
    ev_t e;
    e.t   = t;
    e.sig = s;
    exp_q.push_back(e);
  endtask

  // Expected events of one frame whose start is seen at edge t0+1;
  // only events at relative edge <= lim are pushed.
  task automatic push_frame(input int h, input int n, input logic cpol,
                            input logic cpha, input int t0, input int lim);
    logic ld;
    if (1 <= lim) push_ev(t0 + 1, {cpol, 1'b0, 1'b1, 5'b0});
    for (int k = 1; k <= 2 * n; k++) begin
      ld = (k % 2 == 1);
      if (1 + h * k <= lim)
        push_ev(t0 + 1 + h * k, {cpol ^ ld, 1'b0, 1'b1, 1'b0, ld, !ld,
                                 cpha ? !ld : ld, cpha ? ld : !ld});
    end
    if (1 + h * (2 * n + 1) <= lim) push_ev(t0 + 1 + h * (2 * n + 1), {cpol, 1'b1, 1'b1, 1'b1, 4'b0});
    if (1 + h * (2 * n + 2) <= lim) push_ev(t0 + 1 + h * (2 * n + 2), {cpol, 1'b1, 1'b0, 1'b0, 4'b0});
  endtask

  task automatic wait_cyc(input int t);
    int n = 0;
    while (cyc < t && n < 1000) begin
      @(negedge m_clk);
      n++;
    end
    total++;
    if (cyc != t) begin
      bad++;
      $display("FAIL wait_cyc got=%0d required=%0d", cyc, t);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge m_clk);
      n++;
    end
    repeat (3) @(negedge m_clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  int t0;
  int cs_hi;

  initial begin
    rst = 1'b0; cfg_div = 8'd1; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
    nbits = 6'd8; start = 1'b0;

    // Reset asserted before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_spi_clk", 32'(spi_clk), 32'd0);
    chk("rst_cs_n",    32'(spi_cs_n), 32'd1);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_done",    32'(done), 32'd0);
    chk("rst_strobes", 32'({lead_edge, trail_edge, sample_stb, shift_stb}), 32'd0);
    repeat (2) @(negedge m_clk);
    #2 rst = 1'b0;

    // Idle level follows CPOL
    @(negedge m_clk) cfg_cpol = 1'b1;
    @(negedge m_clk);
    chk("idle_cpol1", 32'(spi_clk), 32'd1);
    cfg_cpol = 1'b0;
    @(negedge m_clk);
    chk("idle_cpol0", 32'(spi_clk), 32'd0);

    // Mode 0, H=2, 8 bits
    {cfg_cpol, cfg_cpha} = SPI_MODE0; cfg_div = 8'd1; nbits = 6'd8;
    start = 1'b1; t0 = cyc;
    push_frame(2, 8, 1'b0, 1'b0, t0, BIG);
    @(negedge m_clk) start = 1'b0;
    drain(200);

    // Mode 3, H=1, nbits=0 -> 64 bits
    {cfg_cpol, cfg_cpha} = SPI_MODE3; cfg_div = 8'd0; nbits = 6'd0;
    @(negedge m_clk);
    start = 1'b1; t0 = cyc;
    push_frame(1, 64, 1'b1, 1'b1, t0, BIG);
    @(negedge m_clk) start = 1'b0;
    drain(400);
    chk("mode3_idle_high", 32'(spi_clk), 32'd1);

    // Mode 1, H=4, 4 bits; config change and start mid-frame are ignored
    {cfg_cpol, cfg_cpha} = SPI_MODE1; cfg_div = 8'd3; nbits = 6'd4;
    @(negedge m_clk);
    start = 1'b1; t0 = cyc;
    push_frame(4, 4, 1'b0, 1'b1, t0, BIG);
    @(negedge m_clk) start = 1'b0;
    wait_cyc(t0 + 13);
    cfg_div = 8'd0; start = 1'b1;
    repeat (3) @(negedge m_clk);
    start = 1'b0;
    drain(200);

    // Reset after the 5th toggle of a mode 0 frame
    {cfg_cpol, cfg_cpha} = SPI_MODE0; cfg_div = 8'd1; nbits = 6'd8;
    @(negedge m_clk);
    start = 1'b1; t0 = cyc;
    push_frame(2, 8, 1'b0, 1'b0, t0, 11);
    @(negedge m_clk) start = 1'b0;
    wait_cyc(t0 + 11);
    #2 rst = 1'b1;
    #1;
    chk("midrst_cs_n",    32'(spi_cs_n), 32'd1);
    chk("midrst_busy",    32'(busy), 32'd0);
    chk("midrst_spi_clk", 32'(spi_clk), 32'd0);
    chk("midrst_done",    32'(done), 32'd0);
    @(negedge m_clk);
    #2 rst = 1'b0;
    chk("midrst_queue", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge m_clk);
    start = 1'b1; t0 = cyc;
    push_frame(2, 8, 1'b0, 1'b0, t0, BIG);
    @(negedge m_clk) start = 1'b0;
    drain(200);

    // Back-to-back frames with start held high, H=3, 1 bit
    cfg_div = 8'd2; nbits = 6'd1;
    @(negedge m_clk);
    start = 1'b1; t0 = cyc;
    push_frame(3, 1, 1'b0, 1'b0, t0, BIG);
    push_frame(3, 1, 1'b0, 1'b0, t0 + 13, BIG);
    wait_cyc(t0 + 9);
    cs_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge m_clk);
      if (spi_cs_n) cs_hi++;
      else break;
    end
    start = 1'b0;
    chk("b2b_cs_high", 32'(cs_hi), 32'd4);
    drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_sclk_gen.md
# spi_sclk_gen

Parametrised SPI master clock and chip-select sequencer; the next generation of the fixed divide-by-ten SPI clock generator. From the system clock `m_clk` it produces a programmable-rate `spi_clk` in all four CPOL/CPHA modes. It also produces a framed `spi_cs_n` with setup, hold and gap times, and per-edge sample/shift strobes for the shift-register datapath. It sits between the SPI control registers and the master shifter.

## Interface
Parameters:
- `DIV_W`, 8: width of the half-period divider field.
- `CNT_W`, 6: width of the bit-count field; maximum frame is 2^CNT_W bits.

Ports:
- `m_clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `cfg_div`  in  DIV_W  half-period is H = cfg_div+1 `m_clk` cycles.
- `cfg_cpol`  in  1  idle level of `spi_clk`.
- `cfg_cpha`  in  1  0: sample on leading edge; 1: sample on trailing edge.
- `nbits`  in  CNT_W  bits per frame; 0 encodes 2^CNT_W.
- `start`  in  1  frame request; accepted only in IDLE.
- `busy`  out  1  high from acceptance through end of GAP.
- `done`  out  1  one-cycle pulse when `spi_cs_n` deasserts.
- `spi_clk`  out  1  serial clock.
- `spi_cs_n`  out  1  chip select, active-low.
- `lead_edge`, `trail_edge`  out  1  one-cycle strobes for the leading (idle→active) and trailing `spi_clk` toggles.
- `sample_stb`, `shift_stb`  out  1  one-cycle strobes.
  - CPHA=0: sample = lead, shift = trail.
  - CPHA=1: shift = lead, sample = trail.

## Operation
- FSM states: IDLE, SETUP, RUN, HOLD, GAP.
- IDLE:
  - `spi_clk` registers `cfg_cpol` each cycle.
  - `start`=1 latches `cfg_div`, `cfg_cpol`, `cfg_cpha` and `nbits`, then goes to SETUP.
- SETUP:
  - `spi_cs_n`=0, `busy`=1, `spi_clk` at idle level.
  - Lasts H cycles, then goes to RUN.
- RUN:
  - `spi_clk` toggles every H cycles, starting H cycles after SETUP entry.
  - Exactly 2·N toggles, where N is the latched bit count.
  - Odd toggles are leading edges; even toggles are trailing edges.
  - After the final (trailing) toggle, goes to HOLD; `spi_clk` is back at idle level.
- HOLD: lasts H cycles. On exit, `spi_cs_n`=1 and `done`=1 for that one cycle, then goes to GAP.
- GAP: lasts H cycles with `busy`=1, then goes to IDLE and `busy`=0.
- Configuration inputs are ignored while `busy`=1; the latched copies govern the whole frame.
- `start` while `busy`=1 is dropped: no queuing, no error.
- Counters:
  - Divider counter is DIV_W bits and counts 0..cfg_div.
  - Edge counter is CNT_W+1 bits to hold 2·2^CNT_W.
  - No wrap-around is visible at any output.
- `cfg_div`=0 (H=1): `spi_clk` = `m_clk`/2; all strobes remain single-cycle.

## Timing
- Reset values: `spi_clk`=0, `spi_cs_n`=1, `busy`=0, `done`=0, all strobes=0; FSM in IDLE; counters zeroed.
- Reset asserted mid-frame forces these values immediately, independent of `m_clk`. No `done` pulse is issued.
- All outputs are registered.
- Every strobe is high in exactly the cycle in which `spi_clk` first shows its new level.
- Cycle numbering: `start` sampled at edge 0.
  - Edge 1: `spi_cs_n`=0, `busy`=1.
  - Toggles at edges 1+H·k, for k=1..2N.
  - `spi_cs_n`=1 and `done`=1 at edge 1+H·(2N+1).
  - `busy`=0 at edge 1+H·(2N+2).
- Back-to-back: `start` held high re-triggers on the first IDLE cycle. Minimum CS-high time is H+1 cycles.

## Structure
- Shared package `spi_pkg` holds:
  - FSM state enum (`SPI_IDLE`, `SPI_SETUP`, `SPI_RUN`, `SPI_HOLD`, `SPI_GAP`).
  - Default `DIV_W`/`CNT_W` constants.
  - Mode encoding constants `SPI_MODE0`..`SPI_MODE3` = {CPOL,CPHA}.
- One natural sub-module, `spi_tick_div`:
  - Loadable half-period counter.
  - Emits a one-cycle `tick` every H cycles while enabled; clears on disable.
- FSM, edge counter and strobe decode live in the top module.

## Test plan
- Reset/idle:
  - `rst` pulse asserted between clock edges → outputs reach reset values before the next `m_clk` edge.
  - With `cfg_cpol`=1, `spi_clk`=1 from the next cycle.
- Mode 0, `cfg_div`=1, `nbits`=8, `start` at edge 0:
  - `spi_cs_n` low at edge 1.
  - `spi_clk` rises at 3 and toggles every 2 cycles to the last fall at 33.
  - 8 `sample_stb` on rises, 8 `shift_stb` on falls.
  - `done` at edge 35; `busy` low at edge 37.
- Mode 3, `cfg_div`=0, `nbits`=0:
  - 64 bits, 128 toggles; `spi_clk` idles high.
  - `shift_stb` on falling edges, `sample_stb` on rising edges.
  - `done` at edge 130.
- Config change and `start` mid-frame, mode 1, `cfg_div`=3, `nbits`=4:
  - At the 3rd toggle, drive `cfg_div`=0 and `start`=1.
  - Toggle spacing stays 4 cycles; frame is unchanged; no second frame starts.
- Reset mid-RUN: assert `rst` after the 5th toggle → no `done`; `spi_cs_n`=1 at once; next `start` gives a full clean frame.
- Back-to-back: `start` held high, `cfg_div`=2, `nbits`=1 → two frames with `spi_cs_n` high for exactly 4 cycles between them.
